// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, one byte per frame.
// The start bit is confirmed at its midpoint, and every later bit is sampled
// a full bit period after the previous sample point. Framing errors enter a
// break state, which waits for the line to return high before listening again.

module uart_rx #(
    parameter int clk_divide = 234
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX,
    output logic [7:0] RX_DATA_OUT,
    output logic       RX_VALID,
    output logic       RX_ACTIVE,
    output logic       RX_ERR
);

    localparam int half_divide = clk_divide / 2;
    localparam int CNT_W       = $clog2(clk_divide);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(clk_divide - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(half_divide - 1);

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_DONE,
        RX_BREAK
    } rx_state_t;

    rx_state_t        state;
    rx_state_t        state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [2:0]       idx;
    logic [2:0]       idx_next;
    logic [7:0]       shift;
    logic [7:0]       shift_next;
    logic [7:0]       data_next;
    logic             valid_next;
    logic             err_next;

    logic             rx_meta;
    logic             rx_s;
    logic [1:0]       sync_fill;
    logic             armed;

    // Two-flop synchronizer. After reset the receiver is armed only once the
    // refilled synchronizer shows the line high, so a frame that was already
    // in progress when reset was released cannot be mistaken for a start bit.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            sync_fill <= 2'b00;
            armed     <= 1'b0;
        end else begin
            rx_meta   <= RX;
            rx_s      <= rx_meta;
            sync_fill <= {sync_fill[0], 1'b1};
            if (sync_fill[1] && rx_s) begin
                armed <= 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= RX_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic, plus the bit timing counter, the shift register and the output pulses.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        shift_next = shift;
        data_next  = RX_DATA_OUT;
        valid_next = 1'b0;
        err_next   = 1'b0;

        case (state)
            RX_IDLE: begin
                if (armed && !rx_s) begin
                    state_next = RX_START;
                    cnt_next   = '0;
                    idx_next   = 3'd0;
                end
            end
            RX_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_next   = '0;
                    state_next = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_next        = '0;
                    shift_next[idx] = rx_s;
                    if (idx == 3'd7) begin
                        state_next = RX_STOP;
                    end else begin
                        idx_next = idx + 3'd1;
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        data_next  = shift;
                        valid_next = 1'b1;
                        state_next = RX_DONE;
                    end else begin
                        err_next   = 1'b1;
                        state_next = RX_BREAK;
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            RX_DONE: begin
                state_next = RX_IDLE;
            end
            RX_BREAK: begin
                if (rx_s) begin
                    state_next = RX_IDLE;
                end
            end
            default: begin
                state_next = RX_IDLE;
                cnt_next   = '0;
                idx_next   = 3'd0;
            end
        endcase
    end

    // Datapath registers. Valid and error are registered, one-cycle pulses.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt         <= '0;
            idx         <= 3'd0;
            shift       <= 8'h00;
            RX_DATA_OUT <= 8'h00;
            RX_VALID    <= 1'b0;
            RX_ERR      <= 1'b0;
        end else begin
            cnt         <= cnt_next;
            idx         <= idx_next;
            shift       <= shift_next;
            RX_DATA_OUT <= data_next;
            RX_VALID    <= valid_next;
            RX_ERR      <= err_next;
        end
    end

    assign RX_ACTIVE = (state == RX_START) || (state == RX_DATA) || (state == RX_STOP);

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx at 16 clocks per bit. Received bytes are compared
// against a queue of expected bytes. Each frame's error pulses and active
// cycles are also compared against the values that frame should produce.
`timescale 1ns/1ps

module tb_uart_rx;

    localparam int DIV       = 16;
    localparam int CLK_NS    = 10;
    localparam int BIT_NS    = DIV * CLK_NS;
    localparam int ACTIVE_CY = 8 + 9 * DIV;

    logic       CLK;
    logic       RST;
    logic       RX;
    logic [7:0] RX_DATA_OUT;
    logic       RX_VALID;
    logic       RX_ACTIVE;
    logic       RX_ERR;

    typedef struct {
        logic [7:0] data;
        int         bit_ns;
        logic       stop_bit;
        logic       expect_valid;
        logic       expect_err;
    } frame_vec_t;

    frame_vec_t vecs [6];
    logic [7:0] exp_q [$];
    logic [7:0] last_good;
    logic [7:0] sb_exp;
    int         checks;
    int         errors;
    int         err_count;
    int         active_count;
    int         errs0;

    uart_rx #(.clk_divide(DIV)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX          (RX),
        .RX_DATA_OUT (RX_DATA_OUT),
        .RX_VALID    (RX_VALID),
        .RX_ACTIVE   (RX_ACTIVE),
        .RX_ERR      (RX_ERR)
    );

    initial begin
        CLK = 1'b0;
        forever #(CLK_NS / 2) CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic driveFrame(input logic [7:0] data, input logic stop_bit, input int bit_ns);
        RX = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            RX = data[i];
            #(bit_ns);
        end
        RX = stop_bit;
        #(bit_ns);
    endtask

    task automatic applyStimulus(input frame_vec_t v);
        if (v.expect_valid) begin
            exp_q.push_back(v.data);
            last_good = v.data;
        end
        @(negedge CLK);
        #2;
        driveFrame(v.data, v.stop_bit, v.bit_ns);
        RX = 1'b1;
        #(20 * CLK_NS);
    endtask

    task automatic runVector(input frame_vec_t v, input string name);
        errs0        = err_count;
        active_count = 0;
        applyStimulus(v);
        checkOutput({name, "_data"}, {24'h0, RX_DATA_OUT}, {24'h0, last_good});
        checkOutput({name, "_err"}, 32'(err_count - errs0), v.expect_err ? 32'd1 : 32'd0);
        checkOutput({name, "_active"}, 32'(active_count), 32'(ACTIVE_CY));
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        err_count    = 0;
        active_count = 0;
        last_good    = 8'h00;
        RX           = 1'b1;
        RST          = 1'b1;

        vecs[0] = '{8'h55, BIT_NS,      1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'h96, BIT_NS - 5,  1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'h96, BIT_NS + 5,  1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'hC4, BIT_NS,      1'b1, 1'b1, 1'b0};
        vecs[4] = '{8'h5A, BIT_NS,      1'b0, 1'b0, 1'b1};
        vecs[5] = '{8'h01, BIT_NS,      1'b1, 1'b1, 1'b0};

        // Scoreboard and pulse monitor, sampling on the falling edge.
        fork
            forever begin
                @(negedge CLK);
                if (RST) begin
                    if (RX_ERR) err_count++;
                    if (RX_ACTIVE) active_count++;
                    if (RX_VALID && RX_ERR) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL valid_err_overlap: got both high expected at most one");
                    end
                    if (RX_VALID) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("[TB] FAIL sb_unexpected_valid: got RX_VALID with data %0h expected no pulse", RX_DATA_OUT);
                        end else begin
                            sb_exp = exp_q.pop_front();
                            checkOutput("sb_data", {24'h0, RX_DATA_OUT}, {24'h0, sb_exp});
                        end
                    end
                end
            end
        join_none

        #3;
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        checkOutput("reset_data", {24'h0, RX_DATA_OUT}, 32'h0);
        checkOutput("reset_valid", {31'h0, RX_VALID}, 32'h0);
        checkOutput("reset_active", {31'h0, RX_ACTIVE}, 32'h0);
        checkOutput("reset_err", {31'h0, RX_ERR}, 32'h0);
        #2;
        RST = 1'b1;
        repeat (10) @(negedge CLK);

        for (int i = 0; i < 6; i++) begin
            runVector(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back frames with no idle gap between them.
        errs0        = err_count;
        active_count = 0;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        last_good = 8'hFF;
        @(negedge CLK);
        #2;
        driveFrame(8'h00, 1'b1, BIT_NS);
        driveFrame(8'hFF, 1'b1, BIT_NS);
        RX = 1'b1;
        #(20 * CLK_NS);
        checkOutput("b2b_data", {24'h0, RX_DATA_OUT}, {24'h0, last_good});
        checkOutput("b2b_err", 32'(err_count - errs0), 32'd0);
        checkOutput("b2b_active", 32'(active_count), 32'(2 * ACTIVE_CY));

        // Short low glitch: rejected at the start-bit midpoint.
        errs0        = err_count;
        active_count = 0;
        @(negedge CLK);
        #2;
        RX = 1'b0;
        #(5 * CLK_NS);
        RX = 1'b1;
        #(40 * CLK_NS);
        checkOutput("glitch_data", {24'h0, RX_DATA_OUT}, {24'h0, last_good});
        checkOutput("glitch_err", 32'(err_count - errs0), 32'd0);
        checkOutput("glitch_active", 32'(active_count), 32'(DIV / 2));

        // Framing error followed by a long break.
        errs0        = err_count;
        active_count = 0;
        @(negedge CLK);
        #2;
        driveFrame(8'hA3, 1'b0, BIT_NS);
        #(100 * CLK_NS);
        RX = 1'b1;
        #(20 * CLK_NS);
        checkOutput("break_data", {24'h0, RX_DATA_OUT}, {24'h0, last_good});
        checkOutput("break_err", 32'(err_count - errs0), 32'd1);
        checkOutput("break_active", 32'(active_count), 32'(ACTIVE_CY));
        runVector('{8'h3C, BIT_NS, 1'b1, 1'b1, 1'b0}, "after_break");

        // Reset in the middle of data bit 4; the rest of that frame is ignored.
        errs0 = err_count;
        @(negedge CLK);
        #2;
        RX = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            RX = 1'b0;
            #(BIT_NS);
        end
        #(BIT_NS / 2);
        RST = 1'b0;
        #1;
        checkOutput("midreset_data", {24'h0, RX_DATA_OUT}, 32'h0);
        checkOutput("midreset_valid", {31'h0, RX_VALID}, 32'h0);
        checkOutput("midreset_active", {31'h0, RX_ACTIVE}, 32'h0);
        checkOutput("midreset_err", {31'h0, RX_ERR}, 32'h0);
        last_good = 8'h00;
        #29;
        RST = 1'b1;
        #(BIT_NS / 2 - 30);
        #(3 * BIT_NS);
        RX = 1'b1;
        #(BIT_NS);
        #(40 * CLK_NS);
        checkOutput("postreset_data", {24'h0, RX_DATA_OUT}, 32'h0);
        checkOutput("postreset_err", 32'(err_count - errs0), 32'd0);
        runVector('{8'h81, BIT_NS, 1'b1, 1'b1, 1'b0}, "after_reset");

        checkOutput("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
